exe_issue_ctrl: RTL and testbench

Instruction issue sequencer for the execute datapath (alu/regs/data_mov). Accepts 32-bit instruction words from fetch over a valid/ready handshake, decodes them, and drives execute with one enable pulse per instruction. Sequences register-file clearing after reset, OUTW output transfers, HALT, illegal-instruction flagging and retire counting.

---
 rtl/exe_issue_ctrl.sv | 168 ++++++++++++++++
 tb/tb_exe_issue_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/exe_issue_ctrl.sv
// Instruction issue sequencer: clears the register file after reset, then issues one fetched word at a time to execute.
// Accepts a word only in IDLE; MV/ALU occupy 2+SETTLE_CYCLES cycles and an OUTW waits on out_ready with its fields held.
module exe_issue_ctrl #(
    parameter int CLR_CYCLES    = 16,
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instr_valid,
    input  logic [31:0]      instr,
    output logic             instr_ready,
    output logic             exe_rst,
    output logic             exe_en,
    output logic [1:0]       exe_pfix,
    output logic [5:0]       exe_opcode,
    output logic [3:0]       exe_rs,
    output logic [3:0]       exe_rd,
    output logic [15:0]      exe_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_rd,
    output logic [15:0]      out_imm,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] retired_cnt
);

    localparam int MAXC = (CLR_CYCLES > SETTLE_CYCLES) ? CLR_CYCLES : SETTLE_CYCLES;
    localparam int TW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [TW-1:0] CLR_LOAD    = TW'(CLR_CYCLES - 1);
    localparam logic [TW-1:0] SETTLE_LOAD = TW'(SETTLE_CYCLES - 1);

    localparam logic [5:0] OP_NOP  = 6'b000000;
    localparam logic [5:0] OP_MV   = 6'b000011;
    localparam logic [5:0] OP_ADD  = 6'b000100;
    localparam logic [5:0] OP_XOR  = 6'b001010;
    localparam logic [5:0] OP_OUTW = 6'b001101;
    localparam logic [5:0] OP_HALT = 6'b111111;

    typedef enum logic [2:0] {
        S_CLR,
        S_IDLE,
        S_ISSUE,
        S_SETTLE,
        S_OUT,
        S_HALT
    } state_t;

    state_t        state, state_nxt;
    logic [TW-1:0] tmr, tmr_nxt;
    logic          accept;
    logic          retire;
    logic          set_illegal;

    // Decode works on the latched fields, which stay put for the whole instruction.
    logic op_mvalu, pfix_ok, is_exec, is_nop, is_outw, is_halt;

    assign op_mvalu = (exe_opcode == OP_MV) ||
                      ((exe_opcode >= OP_ADD) && (exe_opcode <= OP_XOR));
    assign pfix_ok  = (exe_pfix == 2'b00) || (exe_pfix == 2'b11);
    assign is_exec  = op_mvalu && pfix_ok;
    assign is_nop   = (exe_opcode == OP_NOP);
    assign is_outw  = (exe_opcode == OP_OUTW);
    assign is_halt  = (exe_opcode == OP_HALT);

    assign exe_rst     = (state == S_CLR);
    assign instr_ready = (state == S_IDLE);
    assign out_valid   = (state == S_OUT);
    assign halted      = (state == S_HALT);
    assign out_rd      = exe_rd;
    assign out_imm     = exe_imm;

    always_comb begin
        state_nxt   = state;
        tmr_nxt     = tmr;
        accept      = 1'b0;
        retire      = 1'b0;
        set_illegal = 1'b0;
        exe_en      = 1'b0;
        case (state)
            S_CLR: begin
                if (tmr == '0) begin
                    state_nxt = S_IDLE;
                end else begin
                    tmr_nxt = tmr - TW'(1);
                end
            end
            S_IDLE: begin
                if (instr_valid) begin
                    accept    = 1'b1;
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (is_exec) begin
                    exe_en    = 1'b1;
                    tmr_nxt   = SETTLE_LOAD;
                    state_nxt = S_SETTLE;
                end else if (is_nop) begin
                    retire    = 1'b1;
                    state_nxt = S_IDLE;
                end else if (is_outw) begin
                    state_nxt = S_OUT;
                end else if (is_halt) begin
                    retire    = 1'b1;
                    state_nxt = S_HALT;
                end else begin
                    set_illegal = 1'b1;
                    state_nxt   = S_IDLE;
                end
            end
            S_SETTLE: begin
                if (tmr == '0) begin
                    retire    = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    tmr_nxt = tmr - TW'(1);
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    retire    = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_HALT: begin
                state_nxt = S_HALT;
            end
            default: begin
                state_nxt = S_CLR;
                tmr_nxt   = CLR_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_CLR;
            tmr         <= CLR_LOAD;
            exe_pfix    <= '0;
            exe_opcode  <= '0;
            exe_rs      <= '0;
            exe_rd      <= '0;
            exe_imm     <= '0;
            illegal     <= 1'b0;
            retired_cnt <= '0;
        end else begin
            state <= state_nxt;
            tmr   <= tmr_nxt;
            if (accept) begin
                exe_pfix   <= instr[31:30];
                exe_opcode <= instr[29:24];
                exe_rs     <= instr[23:20];
                exe_rd     <= instr[19:16];
                exe_imm    <= instr[15:0];
            end
            if (set_illegal) begin
                illegal <= 1'b1;
            end
            if (retire) begin
                retired_cnt <= retired_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_exe_issue_ctrl.sv
// Directed bench for exe_issue_ctrl; a second instance with a 4-bit retire counter checks wrap-around.
module tb_exe_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic [31:0] instr = '0;
    logic        out_ready = 1'b0;

    logic        instr_ready, exe_rst, exe_en, out_valid, halted, illegal;
    logic [1:0]  exe_pfix;
    logic [5:0]  exe_opcode;
    logic [3:0]  exe_rs, exe_rd, out_rd;
    logic [15:0] exe_imm, out_imm;
    logic [15:0] retired_cnt;

    logic        instr_ready_b, exe_rst_b, exe_en_b, out_valid_b, halted_b, illegal_b;
    logic [1:0]  exe_pfix_b;
    logic [5:0]  exe_opcode_b;
    logic [3:0]  exe_rs_b, exe_rd_b, out_rd_b;
    logic [15:0] exe_imm_b, out_imm_b;
    logic [3:0]  retired_cnt_b;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_cnt  = 0;

    always #5 clk = ~clk;

    exe_issue_ctrl #(.CLR_CYCLES(16), .SETTLE_CYCLES(1), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .exe_rst(exe_rst), .exe_en(exe_en),
        .exe_pfix(exe_pfix), .exe_opcode(exe_opcode), .exe_rs(exe_rs), .exe_rd(exe_rd),
        .exe_imm(exe_imm), .out_valid(out_valid), .out_ready(out_ready),
        .out_rd(out_rd), .out_imm(out_imm), .halted(halted), .illegal(illegal),
        .retired_cnt(retired_cnt)
    );

    exe_issue_ctrl #(.CLR_CYCLES(16), .SETTLE_CYCLES(1), .CNT_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready_b), .exe_rst(exe_rst_b), .exe_en(exe_en_b),
        .exe_pfix(exe_pfix_b), .exe_opcode(exe_opcode_b), .exe_rs(exe_rs_b), .exe_rd(exe_rd_b),
        .exe_imm(exe_imm_b), .out_valid(out_valid_b), .out_ready(out_ready),
        .out_rd(out_rd_b), .out_imm(out_imm_b), .halted(halted_b), .illegal(illegal_b),
        .retired_cnt(retired_cnt_b)
    );

    function automatic logic [31:0] mk(input logic [1:0] p, input logic [5:0] op,
                                       input logic [3:0] rs, input logic [3:0] rd,
                                       input logic [15:0] imm);
        return {p, op, rs, rd, imm};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] w);
        instr       = w;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (instr_ready !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        n_checks++;
        if (instr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_idle_timeout: instr_ready=%b required 1", tag, instr_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        n_checks++; if (exe_rst !== 1'b1)      begin n_fail++; $display("FAIL rst_exe_rst: got %b want 1", exe_rst); end
        n_checks++; if (instr_ready !== 1'b0)  begin n_fail++; $display("FAIL rst_instr_ready: got %b want 0", instr_ready); end
        n_checks++; if ({exe_en, out_valid, halted, illegal} !== 4'b0000)
            begin n_fail++; $display("FAIL rst_flags: got %b want 0000", {exe_en, out_valid, halted, illegal}); end
        n_checks++; if (retired_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_cnt: got %0d want 0", retired_cnt); end
        n_checks++; if ({exe_pfix, exe_opcode, exe_rs, exe_rd, exe_imm} !== 32'd0)
            begin n_fail++; $display("FAIL rst_fields: got %h want 0", {exe_pfix, exe_opcode, exe_rs, exe_rd, exe_imm}); end
        rst_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            if (k > 1) tick();
            n_checks++;
            if (exe_rst !== 1'b1 || instr_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL clr_cycle%0d: exe_rst=%b instr_ready=%b want 1/0", k, exe_rst, instr_ready);
            end
        end
        tick();
        n_checks++;
        if (exe_rst !== 1'b0 || instr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_cycle17: exe_rst=%b instr_ready=%b want 0/1", exe_rst, instr_ready);
        end
        exp_cnt = 0;
    endtask

    task automatic test_back_to_back();
        instr       = mk(2'b11, 6'h04, 4'd0, 4'd2, 16'd5);
        instr_valid = 1'b1;
        tick();
        n_checks++; if (exe_en !== 1'b1 || exe_rst !== 1'b0)
            begin n_fail++; $display("FAIL b2b_pulse1: exe_en=%b exe_rst=%b want 1/0", exe_en, exe_rst); end
        n_checks++; if ({exe_pfix, exe_opcode, exe_rd, exe_imm} !== {2'b11, 6'h04, 4'd2, 16'd5})
            begin n_fail++; $display("FAIL b2b_fields1: got %h want %h", {exe_pfix, exe_opcode, exe_rd, exe_imm}, {2'b11, 6'h04, 4'd2, 16'd5}); end
        instr = mk(2'b00, 6'h04, 4'd2, 4'd3, 16'd0);
        tick();
        n_checks++; if (exe_en !== 1'b0 || instr_ready !== 1'b0)
            begin n_fail++; $display("FAIL b2b_settle: exe_en=%b instr_ready=%b want 0/0", exe_en, instr_ready); end
        tick();
        exp_cnt++;
        n_checks++; if (exe_en !== 1'b0 || instr_ready !== 1'b1 || exe_rd !== 4'd2)
            begin n_fail++; $display("FAIL b2b_idle: exe_en=%b instr_ready=%b rd=%0d want 0/1/2", exe_en, instr_ready, exe_rd); end
        n_checks++; if (retired_cnt !== 16'(exp_cnt))
            begin n_fail++; $display("FAIL b2b_cnt1: got %0d want %0d", retired_cnt, exp_cnt); end
        tick();
        instr_valid = 1'b0;
        n_checks++; if (exe_en !== 1'b1 || exe_opcode !== 6'h04)
            begin n_fail++; $display("FAIL b2b_pulse2: exe_en=%b op=%h want 1/04", exe_en, exe_opcode); end
        n_checks++; if ({exe_pfix, exe_rs, exe_rd} !== {2'b00, 4'd2, 4'd3})
            begin n_fail++; $display("FAIL b2b_fields2: got %h want %h", {exe_pfix, exe_rs, exe_rd}, {2'b00, 4'd2, 4'd3}); end
        tick();
        tick();
        exp_cnt++;
        n_checks++; if (retired_cnt !== 16'(exp_cnt) || exp_cnt != 2)
            begin n_fail++; $display("FAIL b2b_cnt2: got %0d want 2", retired_cnt); end
    endtask

    task automatic test_outw();
        out_ready = 1'b0;
        send(mk(2'b00, 6'h0D, 4'd0, 4'd7, 16'h1234));
        n_checks++; if (out_valid !== 1'b0 || exe_en !== 1'b0)
            begin n_fail++; $display("FAIL outw_issue: out_valid=%b exe_en=%b want 0/0", out_valid, exe_en); end
        tick();
        for (int k = 1; k <= 4; k++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_rd !== 4'd7 || out_imm !== 16'h1234 || instr_ready !== 1'b0 || exe_en !== 1'b0) begin
                n_fail++;
                $display("FAIL outw_hold%0d: valid=%b rd=%0d imm=%h rdy=%b en=%b want 1/7/1234/0/0",
                         k, out_valid, out_rd, out_imm, instr_ready, exe_en);
            end
            tick();
        end
        out_ready = 1'b1;
        n_checks++; if (out_valid !== 1'b1 || retired_cnt !== 16'(exp_cnt))
            begin n_fail++; $display("FAIL outw_xfer: valid=%b cnt=%0d want 1/%0d", out_valid, retired_cnt, exp_cnt); end
        tick();
        out_ready = 1'b0;
        exp_cnt++;
        n_checks++; if (out_valid !== 1'b0 || instr_ready !== 1'b1 || retired_cnt !== 16'(exp_cnt))
            begin n_fail++; $display("FAIL outw_done: valid=%b rdy=%b cnt=%0d want 0/1/%0d", out_valid, instr_ready, retired_cnt, exp_cnt); end
    endtask

    task automatic test_illegal();
        send(mk(2'b01, 6'h03, 4'd1, 4'd2, 16'd3));
        n_checks++; if (exe_en !== 1'b0 || illegal !== 1'b0)
            begin n_fail++; $display("FAIL ill_mv_issue: exe_en=%b illegal=%b want 0/0", exe_en, illegal); end
        tick();
        n_checks++; if (illegal !== 1'b1 || retired_cnt !== 16'(exp_cnt) || instr_ready !== 1'b1)
            begin n_fail++; $display("FAIL ill_mv: illegal=%b cnt=%0d rdy=%b want 1/%0d/1", illegal, retired_cnt, instr_ready, exp_cnt); end
        send(mk(2'b00, 6'h10, 4'd0, 4'd0, 16'd0));
        n_checks++; if (exe_en !== 1'b0)
            begin n_fail++; $display("FAIL ill_op_issue: exe_en=%b want 0", exe_en); end
        tick();
        n_checks++; if (illegal !== 1'b1 || retired_cnt !== 16'(exp_cnt))
            begin n_fail++; $display("FAIL ill_op: illegal=%b cnt=%0d want 1/%0d", illegal, retired_cnt, exp_cnt); end
        send(32'd0);
        n_checks++; if (exe_en !== 1'b0)
            begin n_fail++; $display("FAIL nop_issue: exe_en=%b want 0", exe_en); end
        tick();
        exp_cnt++;
        n_checks++; if (retired_cnt !== 16'(exp_cnt) || instr_ready !== 1'b1)
            begin n_fail++; $display("FAIL nop_retire: cnt=%0d rdy=%b want %0d/1", retired_cnt, instr_ready, exp_cnt); end
    endtask

    task automatic test_halt();
        send(mk(2'b00, 6'h3F, 4'd0, 4'd0, 16'd0));
        n_checks++; if (halted !== 1'b0)
            begin n_fail++; $display("FAIL halt_issue: halted=%b want 0", halted); end
        tick();
        exp_cnt++;
        n_checks++; if (halted !== 1'b1 || retired_cnt !== 16'(exp_cnt))
            begin n_fail++; $display("FAIL halt_enter: halted=%b cnt=%0d want 1/%0d", halted, retired_cnt, exp_cnt); end
        instr       = 32'd0;
        instr_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            n_checks++;
            if (instr_ready !== 1'b0 || halted !== 1'b1 || exe_en !== 1'b0 || retired_cnt !== 16'(exp_cnt)) begin
                n_fail++;
                $display("FAIL halt_stay%0d: rdy=%b halted=%b en=%b cnt=%0d want 0/1/0/%0d",
                         k, instr_ready, halted, exe_en, retired_cnt, exp_cnt);
            end
        end
        instr_valid = 1'b0;
        rst_n = 1'b0;
        tick();
        exp_cnt = 0;
        n_checks++; if (halted !== 1'b0 || exe_rst !== 1'b1 || illegal !== 1'b0 || retired_cnt !== 16'd0)
            begin n_fail++; $display("FAIL halt_reset: halted=%b rst=%b ill=%b cnt=%0d want 0/1/0/0", halted, exe_rst, illegal, retired_cnt); end
        rst_n = 1'b1;
        wait_idle("halt");
    endtask

    task automatic test_reset_mid();
        send(mk(2'b00, 6'h05, 4'd1, 4'd2, 16'd3));
        n_checks++; if (exe_en !== 1'b1)
            begin n_fail++; $display("FAIL mid_issue: exe_en=%b want 1", exe_en); end
        tick();
        rst_n = 1'b0;
        tick();
        n_checks++; if (exe_rst !== 1'b1 || exe_en !== 1'b0 || instr_ready !== 1'b0 || retired_cnt !== 16'd0)
            begin n_fail++; $display("FAIL mid_settle_rst: rst=%b en=%b rdy=%b cnt=%0d want 1/0/0/0", exe_rst, exe_en, instr_ready, retired_cnt); end
        rst_n = 1'b1;
        wait_idle("mid_settle");
        out_ready = 1'b0;
        send(mk(2'b00, 6'h0D, 4'd0, 4'd9, 16'hABCD));
        tick();
        n_checks++; if (out_valid !== 1'b1)
            begin n_fail++; $display("FAIL mid_out_pend: out_valid=%b want 1", out_valid); end
        rst_n = 1'b0;
        tick();
        n_checks++; if (out_valid !== 1'b0 || exe_rst !== 1'b1 || out_rd !== 4'd0 || out_imm !== 16'd0 || retired_cnt !== 16'd0)
            begin n_fail++; $display("FAIL mid_out_rst: valid=%b rst=%b rd=%0d imm=%h cnt=%0d want 0/1/0/0/0", out_valid, exe_rst, out_rd, out_imm, retired_cnt); end
        rst_n = 1'b1;
        wait_idle("mid_out");
        n_checks++; if (out_valid !== 1'b0)
            begin n_fail++; $display("FAIL mid_out_after: out_valid=%b want 0", out_valid); end
        exp_cnt = 0;
    endtask

    task automatic test_wrap();
        for (int k = 0; k < 17; k++) begin
            send(32'd0);
            tick();
            exp_cnt++;
        end
        n_checks++; if (retired_cnt_b !== 4'd1)
            begin n_fail++; $display("FAIL wrap_cnt4: got %0d want 1", retired_cnt_b); end
        n_checks++; if (retired_cnt !== 16'(exp_cnt) || exp_cnt != 17)
            begin n_fail++; $display("FAIL wrap_cnt16: got %0d want 17", retired_cnt); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_back_to_back();
        test_outw();
        test_illegal();
        test_halt();
        test_reset_mid();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
